// File: rtl/demux_1x8_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the 1x8 demux scheduler.
package demux_1x8_scheduler_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Circular first-set-bit finder: returns the first enabled channel at or after start.
module demux_rr_pick
  import demux_1x8_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  pick,
  output logic              found
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
  always_comb begin
    pick  = start;
    found = 1'b0;
    idx   = start;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1x8_scheduler.sv
// Sequencing controller for the 1x8 demux: accepts one word, routes it to a channel
// chosen by burst round-robin or fixed select, and holds it until that channel takes it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no word held; in_ready reflects whether a target is enabled
// SEND    | one word held on out_data/out_valid until out_ready[sel]
module demux_1x8_scheduler
  import demux_1x8_scheduler_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              fix_mode,
  input  logic [SEL_W-1:0]  fix_sel,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [7:0] BURST_LEN_B = 8'(BURST_LEN);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  last_ptr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  rr_start;
  logic [SEL_W-1:0]  rr_pick;
  logic [SEL_W-1:0]  target;
  logic              rr_found;
  logic              burst_cont;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              accept;
  logic              send_done;
  logic [NUM_CH-1:0] out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  assign rr_start = last_ptr_q + 3'd1;

  demux_rr_pick u_rr_pick (
    .mask  (ch_en),
    .start (rr_start),
    .pick  (rr_pick),
    .found (rr_found)
  );

  // Target selection: fixed select, continuing burst, or next enabled channel.
  always_comb begin
    burst_cont = (burst_cnt_q != 8'd0) && ch_en[last_ptr_q];
    target     = rr_pick;
    if (fix_mode) begin
      target = fix_sel;
    end else if (burst_cont) begin
      target = last_ptr_q;
    end
  end

  // Burst counter update for a round-robin accept; wraps to 0 after BURST_LEN words.
  always_comb begin
    burst_cnt_d = (BURST_LEN_B == 8'd1) ? 8'd0 : 8'd1;
    if ((target == last_ptr_q) && (burst_cnt_q != 8'd0)) begin
      burst_cnt_d = ((burst_cnt_q + 8'd1) == BURST_LEN_B) ? 8'd0 : burst_cnt_q + 8'd1;
    end
  end

  // Next-state and handshake decode; in_ready is forced low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    send_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !rst && (fix_mode ? ch_en[fix_sel] : rr_found);
        accept   = in_valid && in_ready;
        if (accept) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready[sel_q]) begin
          send_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Held word, select and round-robin bookkeeping; fixed mode leaves the burst untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_q       <= '0;
      last_ptr_q  <= 3'd7;
      burst_cnt_q <= 8'd0;
    end else if (accept) begin
      out_data_q  <= in_data;
      sel_q       <= target;
      out_valid_q <= onehot8(target);
      if (!fix_mode) begin
        burst_cnt_q <= burst_cnt_d;
        last_ptr_q  <= target;
      end
    end else if (send_done) begin
      out_valid_q <= '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q == ST_SEND);

endmodule

// File: tb/tb_demux_1x8_scheduler.sv
// Self-checking bench: two scheduler instances (BURST_LEN=2 and BURST_LEN=1) share stimulus;
// a behavioural model predicts the channel of every accepted word into per-instance queues.
module tb_demux_1x8_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] in_data;
  logic [7:0] ch_en;
  logic       fix_mode;
  logic [2:0] fix_sel;
  logic [7:0] out_ready;

  logic       in_ready_a, in_ready_b;
  logic [7:0] out_valid_a, out_valid_b;
  logic [0:0] out_data_a, out_data_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  int   m_last[2];
  int   m_cnt[2];
  int   m_bl[2] = '{2, 1};
  int   exp_a[$];
  int   exp_b[$];
  logic exp_d[$];

  always #5 clk = ~clk;

  demux_1x8_scheduler #(.DATA_W(1), .BURST_LEN(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .ch_en(ch_en), .fix_mode(fix_mode), .fix_sel(fix_sel), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_ready(out_ready), .sel(sel_a), .busy(busy_a)
  );

  demux_1x8_scheduler #(.DATA_W(1), .BURST_LEN(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .ch_en(ch_en), .fix_mode(fix_mode), .fix_sel(fix_sel), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_ready(out_ready), .sel(sel_b), .busy(busy_b)
  );

  function automatic logic [7:0] tb_onehot(input int idx);
    logic [7:0] v;
    v = 8'd0;
    if (idx >= 0 && idx < 8) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int model_target(input int k);
    if (fix_mode) return int'(fix_sel);
    if (m_cnt[k] != 0 && ch_en[m_last[k]]) return m_last[k];
    for (int i = 1; i <= 8; i++) begin
      if (ch_en[(m_last[k] + i) % 8]) return (m_last[k] + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 7;
      m_cnt[k]  = 0;
    end
    exp_a.delete();
    exp_b.delete();
    exp_d.delete();
  endtask

  task automatic model_accept(input logic d);
    int t;
    for (int k = 0; k < 2; k++) begin
      t = model_target(k);
      if (k == 0) exp_a.push_back(t);
      else        exp_b.push_back(t);
      if (!fix_mode) begin
        if (t == m_last[k] && m_cnt[k] != 0) begin
          m_cnt[k] = (m_cnt[k] + 1 == m_bl[k]) ? 0 : m_cnt[k] + 1;
        end else begin
          m_cnt[k]  = 1 % m_bl[k];
          m_last[k] = t;
        end
      end
    end
    exp_d.push_back(d);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Offer one word, wait for acceptance, check the held word against the scoreboard,
  // and check the release if out_ready covers both selected channels.
  task automatic send_word(input logic d, output int got_a, output int got_b,
                           output int ea, output int eb);
    int   n;
    logic ed;
    got_a = -1; got_b = -1; ea = -1; eb = -1;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready a=%b b=%b, expected 1", in_ready_a, in_ready_b);
      in_valid = 1'b0;
      return;
    end
    model_accept(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
    ed = exp_d.pop_front();
    got_a = int'(sel_a);
    got_b = int'(sel_b);
    checks++;
    if (out_valid_a !== tb_onehot(ea) || sel_a !== 3'(ea) || out_data_a !== ed || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL word_a: out_valid=%h sel=%0d data=%b busy=%b, expected out_valid=%h sel=%0d data=%b busy=1",
               out_valid_a, sel_a, out_data_a, busy_a, tb_onehot(ea), ea, ed);
    end
    checks++;
    if (out_valid_b !== tb_onehot(eb) || sel_b !== 3'(eb) || out_data_b !== ed || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL word_b: out_valid=%h sel=%0d data=%b busy=%b, expected out_valid=%h sel=%0d data=%b busy=1",
               out_valid_b, sel_b, out_data_b, busy_b, tb_onehot(eb), eb, ed);
    end
    if (out_ready[ea % 8] && out_ready[eb % 8]) begin
      @(posedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || out_valid_a !== 8'h00 || busy_b !== 1'b0 || out_valid_b !== 8'h00) begin
        errors++;
        $display("FAIL release: busy a=%b b=%b out_valid a=%h b=%h, expected 0",
                 busy_a, busy_b, out_valid_a, out_valid_b);
      end
    end
  endtask

  task automatic test_reset();
    ch_en     = 8'hFF;
    fix_mode  = 1'b0;
    fix_sel   = 3'd0;
    out_ready = 8'hFF;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (out_valid_a !== 8'h00 || busy_a !== 1'b0 || sel_a !== 3'd0 || in_ready_a !== 1'b0 ||
        out_data_a !== 1'b0 || out_valid_b !== 8'h00 || busy_b !== 1'b0 || in_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%h busy=%b sel=%0d in_ready=%b data=%b, expected all 0",
               out_valid_a, busy_a, sel_a, in_ready_a, out_data_a);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin_burst();
    int ga, gb, ea, eb;
    do_reset();
    ch_en = 8'hFF; fix_mode = 1'b0; out_ready = 8'hFF;
    for (int i = 0; i < 17; i++) begin
      send_word(1'(i % 2), ga, gb, ea, eb);
      checks++;
      if (ga !== (i / 2) % 8 || gb !== i % 8) begin
        errors++;
        $display("FAIL rr_order word %0d: sel a=%0d b=%0d, expected a=%0d b=%0d",
                 i, ga, gb, (i / 2) % 8, i % 8);
      end
    end
  endtask

  task automatic test_sparse_mask();
    int ga, gb, ea, eb;
    int seq_a[6] = '{2, 2, 5, 5, 7, 7};
    int seq_b[6] = '{2, 5, 7, 2, 5, 7};
    do_reset();
    ch_en = 8'b1010_0100; fix_mode = 1'b0; out_ready = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      send_word(1'b1, ga, gb, ea, eb);
      checks++;
      if (ga !== seq_a[i] || gb !== seq_b[i]) begin
        errors++;
        $display("FAIL sparse_order word %0d: sel a=%0d b=%0d, expected a=%0d b=%0d",
                 i, ga, gb, seq_a[i], seq_b[i]);
      end
    end
  endtask

  task automatic test_fixed_mode();
    int  ga, gb, ea, eb;
    logic bad;
    do_reset();
    ch_en = 8'hFF; fix_mode = 1'b1; fix_sel = 3'd6; out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      send_word(1'(i % 2), ga, gb, ea, eb);
      checks++;
      if (ga !== 6 || gb !== 6) begin
        errors++;
        $display("FAIL fixed_sel word %0d: sel a=%0d b=%0d, expected 6", i, ga, gb);
      end
    end
    ch_en = 8'hBF;
    in_valid = 1'b1; in_data = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0 || out_valid_a !== 8'h00 || out_valid_b !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fixed_disabled: in_ready=%b out_valid=%h, expected 0 and 00", in_ready_a, out_valid_a);
    end
    in_valid = 1'b0;
    fix_mode = 1'b0; ch_en = 8'hFF;
    send_word(1'b0, ga, gb, ea, eb);
    checks++;
    if (ga !== 0 || gb !== 0) begin
      errors++;
      $display("FAIL fixed_keeps_rr: sel a=%0d b=%0d, expected 0", ga, gb);
    end
  endtask

  task automatic test_hold_in_send();
    int   ga, gb, ea, eb;
    logic bad;
    do_reset();
    ch_en = 8'hFF; fix_mode = 1'b0; out_ready = 8'h00;
    send_word(1'b1, ga, gb, ea, eb);
    out_ready = ~(tb_onehot(ea) | tb_onehot(eb));
    in_valid = 1'b1; in_data = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        ch_en = 8'h80;
        fix_mode = 1'b1; fix_sel = 3'd3;
      end
      @(posedge clk); #1;
      if (out_valid_a !== tb_onehot(ea) || sel_a !== 3'(ea) || out_data_a !== 1'b1 || busy_a !== 1'b1 ||
          in_ready_a !== 1'b0 || out_valid_b !== tb_onehot(eb) || sel_b !== 3'(eb) || in_ready_b !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: out_valid=%h sel=%0d busy=%b in_ready=%b, expected %h %0d 1 0",
               out_valid_a, sel_a, busy_a, in_ready_a, tb_onehot(ea), ea);
    end
    fix_mode = 1'b0; ch_en = 8'hFF;
    in_valid = 1'b0;
    out_ready = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || out_valid_a !== 8'h00 || in_ready_a !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: busy=%b out_valid=%h in_ready=%b, expected 0 00 1",
               busy_a, out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_async_reset();
    int ga, gb, ea, eb;
    do_reset();
    ch_en = 8'h08; fix_mode = 1'b0; out_ready = 8'h00;
    send_word(1'b1, ga, gb, ea, eb);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_a !== 8'h00 || busy_a !== 1'b0 || sel_a !== 3'd0 ||
        out_valid_b !== 8'h00 || busy_b !== 1'b0 || sel_b !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%h busy=%b sel=%0d, expected 00 0 0", out_valid_a, busy_a, sel_a);
    end
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    ch_en = 8'b0011_0000; out_ready = 8'hFF;
    send_word(1'b0, ga, gb, ea, eb);
    checks++;
    if (ga !== 4 || gb !== 4) begin
      errors++;
      $display("FAIL after_reset: sel a=%0d b=%0d, expected 4", ga, gb);
    end
  endtask

  task automatic test_no_channel();
    int   ga, gb, ea, eb;
    logic bad;
    do_reset();
    ch_en = 8'h00; fix_mode = 1'b0; out_ready = 8'hFF;
    in_valid = 1'b1; in_data = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (in_ready_a !== 1'b0 || out_valid_a !== 8'h00 || in_ready_b !== 1'b0 || out_valid_b !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_channel: in_ready=%b out_valid=%h, expected 0 00", in_ready_a, out_valid_a);
    end
    ch_en = 8'h10;
    send_word(1'b1, ga, gb, ea, eb);
    checks++;
    if (ga !== 4 || gb !== 4) begin
      errors++;
      $display("FAIL late_enable: sel a=%0d b=%0d, expected 4", ga, gb);
    end
  endtask

  task automatic test_burst_break();
    int ga, gb, ea, eb;
    int seq_a[4] = '{1, 1, 2, 2};
    int seq_b[4] = '{1, 2, 2, 2};
    do_reset();
    ch_en = 8'hFF; fix_mode = 1'b0; out_ready = 8'hFF;
    send_word(1'b1, ga, gb, ea, eb);
    ch_en = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) ch_en = 8'h04;
      send_word(1'(i % 2), ga, gb, ea, eb);
      checks++;
      if (ga !== seq_a[i] || gb !== seq_b[i]) begin
        errors++;
        $display("FAIL burst_break word %0d: sel a=%0d b=%0d, expected a=%0d b=%0d",
                 i, ga, gb, seq_a[i], seq_b[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0;
    ch_en = 8'h00; fix_mode = 1'b0; fix_sel = 3'd0; out_ready = 8'h00;
    test_reset();
    test_round_robin_burst();
    test_sparse_mask();
    test_fixed_mode();
    test_hold_in_send();
    test_async_reset();
    test_no_channel();
    test_burst_break();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
